// File: rtl/scorehand_pkg.sv
// Shared card codes, FSM state type and the face-value-to-points mapping for the hand scorer.
package scorehand_pkg;

  localparam int unsigned TOT_W = 4;

  localparam logic [3:0] CARD_NONE = 4'd0;
  localparam logic [3:0] CARD_ACE  = 4'd1;
  localparam logic [3:0] CARD_TEN  = 4'd10;
  localparam logic [3:0] CARD_KING = 4'd13;

  typedef enum logic [1:0] {IDLE, DEAL, DONE} state_t;

  // Ace..nine score face value; ten and court cards score nothing.
  function automatic logic [3:0] card_points(input logic [3:0] code);
    if (code >= CARD_ACE && code < CARD_TEN) begin
      return code;
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/card_points_lut.sv
// Combinational card decode: points for a card code plus a flag for legal codes (ace..king).
module card_points_lut
  import scorehand_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] points,
  output logic       legal
);

  assign points = card_points(code);
  assign legal  = (code >= CARD_ACE) && (code <= CARD_KING);

endmodule

// File: rtl/scorehand_acc.sv
// Multi-hand registered score accumulator with a valid/ready card input.
// Optional macro SCOREHAND_NATURAL_EN enables natural (8/9 on two cards) detection and game lock.
module scorehand_acc
  import scorehand_pkg::*;
#(
  parameter int unsigned NUM_HANDS = 2,
  parameter int unsigned MAX_CARDS = 3,
  parameter int unsigned MOD       = 10,
  localparam int unsigned HAND_W   = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int unsigned CNT_W    = $clog2(MAX_CARDS + 1)
) (
  input  logic                       slow_clock,
  input  logic                       resetb,
  input  logic                       clear,
  input  logic                       card_valid,
  output logic                       card_ready,
  input  logic [HAND_W-1:0]          card_hand,
  input  logic [3:0]                 card_code,
  output logic [NUM_HANDS*TOT_W-1:0] totals,
  output logic [NUM_HANDS*CNT_W-1:0] counts,
  output logic [NUM_HANDS-1:0]       hand_full,
  output logic [NUM_HANDS-1:0]       natural,
  output logic                       card_err,
  output logic                       game_done
);

  logic [TOT_W-1:0] total_q [NUM_HANDS];
  logic [TOT_W-1:0] total_d [NUM_HANDS];
  logic [CNT_W-1:0] cnt_q   [NUM_HANDS];
  logic [CNT_W-1:0] cnt_d   [NUM_HANDS];
  logic [NUM_HANDS-1:0] nat_q, nat_d;
  state_t state_q, state_d;
  logic   err_q, err_d;

  logic [3:0] points;
  logic       legal, hand_ok, full_sel, accept, scored, all_full_d;
  logic [4:0] sum;

  card_points_lut u_lut (
    .code   (card_code),
    .points (points),
    .legal  (legal)
  );

  always_comb begin
    totals = '0;
    counts = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      hand_full[h]                  = (cnt_q[h] == CNT_W'(MAX_CARDS));
      totals[h*TOT_W +: TOT_W]      = total_q[h];
      counts[h*CNT_W +: CNT_W]      = cnt_q[h];
    end
  end

  // Out-of-range hand indices look "not full" so the card is consumed and flagged.
  always_comb begin
    hand_ok  = 1'b0;
    full_sel = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (card_hand == HAND_W'(h)) begin
        hand_ok  = 1'b1;
        full_sel = hand_full[h];
      end
    end
    card_ready = !clear && (state_q != DONE) && !full_sel;
    accept     = card_valid && card_ready;
    scored     = accept && legal && hand_ok;
    err_d      = accept && !(legal && hand_ok);
  end

  always_comb begin
    sum        = '0;
    all_full_d = 1'b1;
    for (int h = 0; h < NUM_HANDS; h++) begin
      total_d[h] = total_q[h];
      cnt_d[h]   = cnt_q[h];
      nat_d[h]   = nat_q[h];
      if (clear) begin
        total_d[h] = '0;
        cnt_d[h]   = '0;
        nat_d[h]   = 1'b0;
      end else if (scored && (card_hand == HAND_W'(h))) begin
        // Single conditional subtract is enough: total < MOD and points <= 9.
        sum        = {1'b0, total_q[h]} + {1'b0, points};
        total_d[h] = (sum >= 5'(MOD)) ? TOT_W'(sum - 5'(MOD)) : sum[TOT_W-1:0];
        cnt_d[h]   = cnt_q[h] + 1'b1;
`ifdef SCOREHAND_NATURAL_EN
        if ((cnt_d[h] == CNT_W'(2)) && ((total_d[h] == 4'd8) || (total_d[h] == 4'd9))) begin
          nat_d[h] = 1'b1;
        end
`endif
      end
      if (cnt_d[h] != CNT_W'(MAX_CARDS)) begin
        all_full_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (scored) state_d = DEAL;
        DEAL:    if (all_full_d || (|nat_d)) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        total_q[h] <= '0;
        cnt_q[h]   <= '0;
      end
      nat_q   <= '0;
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        total_q[h] <= total_d[h];
        cnt_q[h]   <= cnt_d[h];
      end
      nat_q   <= nat_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign natural   = nat_q;
  assign card_err  = err_q;
  assign game_done = (state_q == DONE);

endmodule

// File: tb/tb_scorehand_acc.sv
// Randomized self-checking bench for scorehand_acc: a default instance and a 3-hand, mod-12 one.
module tb_scorehand_acc;

`ifdef SCOREHAND_NATURAL_EN
  localparam bit NAT_EN = 1'b1;
`else
  localparam bit NAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetb;

  logic       a_clear, a_valid, a_ready, a_err, a_done;
  logic [0:0] a_hand;
  logic [3:0] a_code, a_counts;
  logic [7:0] a_totals;
  logic [1:0] a_full, a_nat;

  logic        b_clear, b_valid, b_ready, b_err, b_done;
  logic [1:0]  b_hand;
  logic [3:0]  b_code;
  logic [11:0] b_totals;
  logic [8:0]  b_counts;
  logic [2:0]  b_full, b_nat;

  scorehand_acc u_dut_a (
    .slow_clock (clk),      .resetb    (resetb),   .clear     (a_clear),
    .card_valid (a_valid),  .card_ready(a_ready),  .card_hand (a_hand),
    .card_code  (a_code),   .totals    (a_totals), .counts    (a_counts),
    .hand_full  (a_full),   .natural   (a_nat),    .card_err  (a_err),
    .game_done  (a_done)
  );

  scorehand_acc #(.NUM_HANDS(3), .MAX_CARDS(5), .MOD(12)) u_dut_b (
    .slow_clock (clk),      .resetb    (resetb),   .clear     (b_clear),
    .card_valid (b_valid),  .card_ready(b_ready),  .card_hand (b_hand),
    .card_code  (b_code),   .totals    (b_totals), .counts    (b_counts),
    .hand_full  (b_full),   .natural   (b_nat),    .card_err  (b_err),
    .game_done  (b_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: raw point sums per hand; the total is simply sum mod MOD.
  int m_sum [2][4];
  int m_cnt [2][4];
  bit m_nat [2][4];
  bit m_done[2];
  bit m_err [2];

  function automatic int nh(input int d); return (d == 0) ? 2 : 3;   endfunction
  function automatic int mc(input int d); return (d == 0) ? 3 : 5;   endfunction
  function automatic int md(input int d); return (d == 0) ? 10 : 12; endfunction
  function automatic int m_tot(input int d, input int h); return m_sum[d][h] % md(d); endfunction

  function automatic logic [3:0] obs_tot(input int d, input int h);
    return (d == 0) ? a_totals[h*4 +: 4] : b_totals[h*4 +: 4];
  endfunction
  function automatic logic [2:0] obs_cnt(input int d, input int h);
    return (d == 0) ? {1'b0, a_counts[h*2 +: 2]} : b_counts[h*3 +: 3];
  endfunction
  function automatic logic obs_full(input int d, input int h);
    return (d == 0) ? a_full[h] : b_full[h];
  endfunction
  function automatic logic obs_nat(input int d, input int h);
    return (d == 0) ? a_nat[h] : b_nat[h];
  endfunction
  function automatic logic obs_ready(input int d); return (d == 0) ? a_ready : b_ready; endfunction
  function automatic logic obs_err(input int d);   return (d == 0) ? a_err : b_err;     endfunction
  function automatic logic obs_done(input int d);  return (d == 0) ? a_done : b_done;   endfunction

  function automatic void model_reset(input int d);
    for (int h = 0; h < 4; h++) begin
      m_sum[d][h] = 0;
      m_cnt[d][h] = 0;
      m_nat[d][h] = 1'b0;
    end
    m_done[d] = 1'b0;
    m_err[d]  = 1'b0;
  endfunction

  function automatic bit model_ready(input int d, input int h);
    return !m_done[d] && !((h < nh(d)) && (m_cnt[d][h] == mc(d)));
  endfunction

  function automatic void model_card(input int d, input int h, input int c);
    bit legal, all_full, any_nat;
    if (!model_ready(d, h)) begin
      m_err[d] = 1'b0;
      return;
    end
    legal    = (c >= 1) && (c <= 13) && (h < nh(d));
    m_err[d] = !legal;
    if (!legal) return;
    m_sum[d][h] += (c <= 9) ? c : 0;
    m_cnt[d][h] += 1;
    if (NAT_EN && (m_cnt[d][h] == 2) && (m_tot(d, h) == 8 || m_tot(d, h) == 9)) m_nat[d][h] = 1'b1;
    all_full = 1'b1;
    any_nat  = 1'b0;
    for (int k = 0; k < nh(d); k++) begin
      if (m_cnt[d][k] != mc(d)) all_full = 1'b0;
      if (m_nat[d][k]) any_nat = 1'b1;
    end
    m_done[d] = all_full || any_nat;
  endfunction

  task automatic drive(input int d, input bit v, input int h, input int c, input bit clr);
    if (d == 0) begin
      a_valid = v; a_hand = 1'(h); a_code = 4'(c); a_clear = clr;
    end else begin
      b_valid = v; b_hand = 2'(h); b_code = 4'(c); b_clear = clr;
    end
  endtask

  // Offer one card for one cycle; checks the combinational ready before the edge.
  task automatic send(input int d, input int h, input int c);
    bit exp_rdy;
    @(negedge clk);
    drive(d, 1'b1, h, c, 1'b0);
    #1;
    exp_rdy = model_ready(d, h);
    checks++;
    if (obs_ready(d) !== exp_rdy) begin
      errors++;
      $display("FAIL ready dut%0d hand%0d code%0d: got %b exp %b", d, h, c, obs_ready(d), exp_rdy);
    end
    @(posedge clk);
    model_card(d, h, c);
    #1;
    drive(d, 1'b0, 0, 0, 1'b0);
  endtask

  // Clear with a card offered the same cycle; the card must be refused.
  task automatic do_clear(input int d, input int h, input int c);
    @(negedge clk);
    drive(d, 1'b1, h, c, 1'b1);
    #1;
    checks++;
    if (obs_ready(d) !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready dut%0d: got %b exp 0", d, obs_ready(d));
    end
    @(posedge clk);
    model_reset(d);
    #1;
    drive(d, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_ready(d) !== 1'b1 || obs_done(d) !== 1'b0 || obs_err(d) !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: ready/done/err got %b%b%b exp 100",
                 d, obs_ready(d), obs_done(d), obs_err(d));
      end
      for (int h = 0; h < nh(d); h++) begin
        checks++;
        if (obs_tot(d, h) !== 4'd0 || obs_cnt(d, h) !== 3'd0 || obs_full(d, h) !== 1'b0 ||
            obs_nat(d, h) !== 1'b0) begin
          errors++;
          $display("FAIL reset_hand dut%0d h%0d: tot %0d cnt %0d full %b nat %b exp all 0",
                   d, h, obs_tot(d, h), obs_cnt(d, h), obs_full(d, h), obs_nat(d, h));
        end
      end
    end
    resetb = 1'b1;
  endtask

  task automatic test_pair();
    send(0, 0, 7);
    send(0, 0, 8);
    @(negedge clk);
    checks++;
    if (obs_tot(0, 0) !== 4'(m_tot(0, 0)) || obs_cnt(0, 0) !== 3'(m_cnt[0][0])) begin
      errors++;
      $display("FAIL pair_7_8: tot %0d cnt %0d exp tot %0d cnt %0d",
               obs_tot(0, 0), obs_cnt(0, 0), m_tot(0, 0), m_cnt[0][0]);
    end
    checks++;
    if (obs_nat(0, 0) !== 1'b0 || obs_err(0) !== 1'b0) begin
      errors++;
      $display("FAIL pair_flags: nat %b err %b exp 0 0", obs_nat(0, 0), obs_err(0));
    end
  endtask

  task automatic test_natural();
    send(0, 1, 9);
    send(0, 1, 13);
    @(negedge clk);
    checks++;
    if (obs_tot(0, 1) !== 4'(m_tot(0, 1)) || obs_nat(0, 1) !== m_nat[0][1]) begin
      errors++;
      $display("FAIL natural_hand1: tot %0d nat %b exp tot %0d nat %b",
               obs_tot(0, 1), obs_nat(0, 1), m_tot(0, 1), m_nat[0][1]);
    end
    checks++;
    if (obs_done(0) !== m_done[0]) begin
      errors++;
      $display("FAIL natural_done: got %b exp %b", obs_done(0), m_done[0]);
    end
    send(0, 0, 2);
    @(negedge clk);
    checks++;
    if (obs_tot(0, 0) !== 4'(m_tot(0, 0)) || obs_cnt(0, 0) !== 3'(m_cnt[0][0])) begin
      errors++;
      $display("FAIL natural_lock: tot %0d cnt %0d exp tot %0d cnt %0d",
               obs_tot(0, 0), obs_cnt(0, 0), m_tot(0, 0), m_cnt[0][0]);
    end
  endtask

  task automatic test_full();
    do_clear(0, 0, 5);
    send(0, 0, 2);
    send(0, 0, 3);
    send(0, 0, 4);
    @(negedge clk);
    checks++;
    if (obs_full(0, 0) !== 1'b1 || obs_full(0, 1) !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: full %b%b exp 01", obs_full(0, 1), obs_full(0, 0));
    end
    send(0, 0, int'($urandom_range(1, 13)));
    @(negedge clk);
    checks++;
    if (obs_tot(0, 0) !== 4'(m_tot(0, 0)) || obs_cnt(0, 0) !== 3'(mc(0))) begin
      errors++;
      $display("FAIL full_unchanged: tot %0d cnt %0d exp tot %0d cnt %0d",
               obs_tot(0, 0), obs_cnt(0, 0), m_tot(0, 0), mc(0));
    end
  endtask

  task automatic test_reject();
    int codes [3] = '{0, 14, 15};
    do_clear(0, 1, 3);
    foreach (codes[i]) begin
      send(0, i % 2, codes[i]);
      @(negedge clk);
      checks++;
      if (obs_err(0) !== 1'b1 || obs_cnt(0, i % 2) !== 3'(m_cnt[0][i % 2])) begin
        errors++;
        $display("FAIL reject_code%0d: err %b cnt %0d exp err 1 cnt %0d",
                 codes[i], obs_err(0), obs_cnt(0, i % 2), m_cnt[0][i % 2]);
      end
      @(negedge clk);
      checks++;
      if (obs_err(0) !== 1'b0) begin
        errors++;
        $display("FAIL reject_pulse%0d: err %b exp 0", codes[i], obs_err(0));
      end
    end
    send(1, 3, 5);
    @(negedge clk);
    checks++;
    if (obs_err(1) !== 1'b1 || b_counts !== 9'd0 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL reject_hand3: err %b counts %0h done %b exp 1 0 0", obs_err(1), b_counts, b_done);
    end
  endtask

  task automatic test_clear_priority();
    send(0, 0, 4);
    send(0, 1, 6);
    do_clear(0, 0, 9);
    @(negedge clk);
    checks++;
    if (a_totals !== 8'd0 || a_counts !== 4'd0 || a_nat !== 2'd0 || a_done !== 1'b0 ||
        a_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_state: tot %0h cnt %0h nat %b done %b ready %b exp 0 0 0 0 1",
               a_totals, a_counts, a_nat, a_done, a_ready);
    end
  endtask

  task automatic test_async_reset();
    send(0, 0, 3);
    send(0, 1, 5);
    send(1, 2, 7);
    @(negedge clk);
    #2 resetb = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    checks++;
    if (a_totals !== 8'd0 || a_counts !== 4'd0 || b_totals !== 12'd0 || b_counts !== 9'd0 ||
        a_err !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: a tot %0h cnt %0h b tot %0h cnt %0h err %b done %b exp all 0",
               a_totals, a_counts, b_totals, b_counts, a_err, a_done);
    end
    @(negedge clk);
    resetb = 1'b1;
  endtask

  task automatic test_sweep();
    for (int it = 0; it < 250; it++) begin
      int d;
      d = it % 2;
      if (m_done[d]) begin
        do_clear(d, 0, int'($urandom_range(0, 15)));
      end else begin
        // Two cards in consecutive cycles, hands chosen independently.
        send(d, int'($urandom_range(0, d == 0 ? 1 : 3)), int'($urandom_range(0, 15)));
        send(d, int'($urandom_range(0, d == 0 ? 1 : 3)), int'($urandom_range(0, 15)));
      end
      @(negedge clk);
      for (int h = 0; h < nh(d); h++) begin
        checks++;
        if (obs_tot(d, h) !== 4'(m_tot(d, h)) || obs_cnt(d, h) !== 3'(m_cnt[d][h]) ||
            obs_nat(d, h) !== m_nat[d][h] || obs_full(d, h) !== (m_cnt[d][h] == mc(d))) begin
          errors++;
          $display("FAIL sweep it%0d dut%0d h%0d: tot %0d cnt %0d nat %b exp tot %0d cnt %0d nat %b",
                   it, d, h, obs_tot(d, h), obs_cnt(d, h), obs_nat(d, h),
                   m_tot(d, h), m_cnt[d][h], m_nat[d][h]);
        end
        checks++;
        if (int'(obs_tot(d, h)) >= md(d)) begin
          errors++;
          $display("FAIL sweep_range it%0d dut%0d h%0d: tot %0d exp < %0d", it, d, h,
                   obs_tot(d, h), md(d));
        end
      end
      checks++;
      if (obs_done(d) !== m_done[d] || obs_err(d) !== m_err[d]) begin
        errors++;
        $display("FAIL sweep_ctrl it%0d dut%0d: done %b err %b exp done %b err %b",
                 it, d, obs_done(d), obs_err(d), m_done[d], m_err[d]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pair();
    test_natural();
    test_full();
    test_reject();
    test_clear_priority();
    test_async_reset();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
